// File: rtl/mem_pkg.sv
// Shared memory-subsystem encodings: access size codes, error codes and the
// LSU state encoding. Also imported by the ram and the bus decoder.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE    = 2'b10;
   localparam logic [1:0] ERR_SIZE     = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/lsu_addr_check.sv
// Effective-address generation and request classification (size, alignment,
// window range), purely combinational.
module lsu_addr_check
   import mem_pkg::*;
#(
   parameter logic [31:0] MEM_BASE = 32'h0000_0000,
   parameter int unsigned MEM_SIZE = 1024
) (
   input  logic [31:0] base,
   input  logic [31:0] offset,
   input  logic [1:0]  size,
   output logic [31:0] ea,
   output logic [1:0]  err
);

   logic [31:0] rel;

   assign ea  = base + offset;
   // An address below MEM_BASE wraps to a huge offset, so one compare covers both bounds.
   assign rel = ea - MEM_BASE;

   always_comb begin
      err = ERR_OK;
      if (size == SZ_ILL) begin
         err = ERR_SIZE;
      end else if ((size == SZ_HALF && ea[0]) ||
                   (size == SZ_WORD && ea[1:0] != 2'b00)) begin
         err = ERR_MISALIGN;
      end else if (rel >= 32'(MEM_SIZE)) begin
         err = ERR_RANGE;
      end
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding request, a single-cycle RAM access and a
// registered response held until writeback takes it.
module lsu
   import mem_pkg::*;
#(
   parameter logic [31:0] MEM_BASE = 32'h0000_0000,
   parameter int unsigned MEM_SIZE = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_base_i,
   input  logic [31:0] req_offset_i,
   input  logic [31:0] req_wdata_i,
   input  logic [4:0]  req_rd_i,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   output logic        ram_we_o,
   output logic [1:0]  ram_hb_o,
   output logic        ram_uload_o,
   input  logic [31:0] ram_rdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic [4:0]  resp_rd_o,
   output logic [1:0]  resp_err_o
);

   logic [1:0]  state;
   logic [31:0] ea_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [4:0]  rd_q;
   logic [1:0]  err_q;
   logic [31:0] rdata_q;
   logic [31:0] chk_ea;
   logic [1:0]  chk_err;

   lsu_addr_check #(
      .MEM_BASE(MEM_BASE),
      .MEM_SIZE(MEM_SIZE)
   ) u_addr_check (
      .base   (req_base_i),
      .offset (req_offset_i),
      .size   (req_size_i),
      .ea     (chk_ea),
      .err    (chk_err)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         ea_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_WORD;
         uns_q   <= 1'b0;
         rd_q    <= '0;
         err_q   <= ERR_OK;
         rdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  ea_q    <= chk_ea;
                  wdata_q <= req_wdata_i;
                  we_q    <= req_we_i;
                  size_q  <= req_size_i;
                  uns_q   <= req_unsigned_i;
                  rd_q    <= req_rd_i;
                  err_q   <= chk_err;
                  rdata_q <= '0;
                  state   <= (chk_err != ERR_OK) ? ST_RESP : ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               rdata_q <= we_q ? 32'd0 : ram_rdata_i;
               state   <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready_i) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // RAM strobes are gated by state, so an async reset drops them at once.
   assign req_ready_o  = (state == ST_IDLE) && !rst_i;
   assign ram_addr_o   = ea_q;
   assign ram_wdata_o  = wdata_q;
   assign ram_we_o     = (state == ST_ACCESS) && we_q;
   assign ram_hb_o     = (state == ST_ACCESS) ? size_q : SZ_WORD;
   assign ram_uload_o  = (state == ST_ACCESS) && uns_q;
   assign resp_valid_o = (state == ST_RESP);
   assign resp_rdata_o = rdata_q;
   assign resp_rd_o    = rd_q;
   assign resp_err_o   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu with a byte-array RAM and a behavioural model.
module tb_lsu;

   localparam int MSZ = 1024;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_base_i, req_offset_i, req_wdata_i;
   logic [4:0]  req_rd_i;
   logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
   logic        ram_we_o, ram_uload_o;
   logic [1:0]  ram_hb_o;
   logic        resp_valid_o, resp_ready_i;
   logic [31:0] resp_rdata_o;
   logic [4:0]  resp_rd_o;
   logic [1:0]  resp_err_o;

   logic [7:0] ram_mem [MSZ] = '{default: 8'h00};
   logic [7:0] ref_mem [MSZ] = '{default: 8'h00};
   int we_cnt = 0;
   int n_checks = 0;
   int n_fail = 0;

   lsu #(.MEM_BASE(32'h0), .MEM_SIZE(MSZ)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .req_base_i(req_base_i), .req_offset_i(req_offset_i),
      .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
      .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o),
      .ram_hb_o(ram_hb_o), .ram_uload_o(ram_uload_o), .ram_rdata_i(ram_rdata_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_rdata_o(resp_rdata_o), .resp_rd_o(resp_rd_o), .resp_err_o(resp_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Little-endian byte RAM: writes on the clock, combinational extended reads.
   always @(posedge clk_i) begin
      if (ram_we_o) begin
         we_cnt <= we_cnt + 1;
         ram_mem[ram_addr_o[9:0]] <= ram_wdata_o[7:0];
         if (ram_hb_o != 2'b00) ram_mem[ram_addr_o[9:0] + 10'd1] <= ram_wdata_o[15:8];
         if (ram_hb_o == 2'b10) begin
            ram_mem[ram_addr_o[9:0] + 10'd2] <= ram_wdata_o[23:16];
            ram_mem[ram_addr_o[9:0] + 10'd3] <= ram_wdata_o[31:24];
         end
      end
   end

   logic [9:0] ra;
   logic [7:0] b0, b1, b2, b3;
   always_comb begin
      ra = ram_addr_o[9:0];
      b0 = ram_mem[ra];
      b1 = ram_mem[ra + 10'd1];
      b2 = ram_mem[ra + 10'd2];
      b3 = ram_mem[ra + 10'd3];
      case (ram_hb_o)
         2'b00:   ram_rdata_i = ram_uload_o ? {24'd0, b0} : {{24{b0[7]}}, b0};
         2'b01:   ram_rdata_i = ram_uload_o ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
         default: ram_rdata_i = {b3, b2, b1, b0};
      endcase
   end

   // Reference: classify by plain arithmetic, keep memory as bytes, apply stores.
   task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] wdata, output logic [1:0] err,
                        output logic [31:0] rdata, output int lat, output int pulses);
      logic [31:0] ea;
      int unsigned v, a, nb;
      ea = base + off;
      if (sz == 2'd3) err = 2'd3;
      else if ((sz == 2'd1 && ea % 2 != 0) || (sz == 2'd2 && ea % 4 != 0)) err = 2'd1;
      else if (ea >= MSZ) err = 2'd2;
      else err = 2'd0;
      rdata  = 32'd0;
      lat    = (err == 2'd0) ? 2 : 1;
      pulses = (err == 2'd0 && we) ? 1 : 0;
      if (err == 2'd0) begin
         a  = ea;
         nb = 1 << sz;
         if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[a + i] = 8'(wdata >> (8 * i));
         end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[a + i]) << (8 * i));
            if (!uns && nb < 4 && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
            rdata = v;
         end
      end
   endtask

   // Drives one request to completion and reports what was observed.
   task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] wdata, input logic [4:0] rd, input bit hs,
                          output logic [31:0] o_rdata, output logic [1:0] o_err,
                          output logic [4:0] o_rd, output int lat, output int pulses,
                          output logic [1:0] o_hb, output logic [31:0] o_addr,
                          output logic o_ul);
      int w0, guard;
      w0 = we_cnt;
      req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
      req_base_i = base; req_offset_i = off; req_wdata_i = wdata; req_rd_i = rd;
      req_valid_i = 1'b1;
      guard = 0;
      while (!req_ready_o && guard < 50) begin
         @(posedge clk_i); #1; guard++;
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      lat = 1; o_hb = 2'b10; o_addr = 32'd0; o_ul = 1'b0;
      while (!resp_valid_o && lat < 20) begin
         o_hb = ram_hb_o; o_addr = ram_addr_o; o_ul = ram_uload_o;
         @(posedge clk_i); #1; lat++;
      end
      if (!resp_valid_o) lat = -1;
      o_rdata = resp_rdata_o; o_err = resp_err_o; o_rd = resp_rd_o;
      if (hs) begin
         resp_ready_i = 1'b1;
         @(posedge clk_i); #1;
         resp_ready_i = 1'b0;
      end
      pulses = we_cnt - w0;
   endtask

   logic [31:0] o_rdata, e_rdata, o_addr;
   logic [1:0]  o_err, e_err, o_hb;
   logic [4:0]  o_rd;
   logic        o_ul;
   int          o_lat, e_lat, o_pul, e_pul;

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      n_checks++;
      if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b0 || ram_we_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready=%b valid=%b we=%b, required 0 0 0", req_ready_o, resp_valid_o, ram_we_o);
      end
      n_checks++;
      if (ram_hb_o !== 2'b10 || ram_uload_o !== 1'b0 || ram_addr_o !== 32'd0 || ram_wdata_o !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_ram: hb=%b ul=%b addr=%h wdata=%h, required 10 0 0 0", ram_hb_o, ram_uload_o, ram_addr_o, ram_wdata_o);
      end
      n_checks++;
      if (resp_rdata_o !== 32'd0 || resp_rd_o !== 5'd0 || resp_err_o !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_resp: rdata=%h rd=%0d err=%b, required 0", resp_rdata_o, resp_rd_o, resp_err_o);
      end
      rst_i = 1'b0;
      #1;
      n_checks++;
      if (req_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b required 1", req_ready_o);
      end
   endtask

   task automatic test_word_store_load();
      model(1'b1, 2'b10, 1'b0, 32'h100, 32'h4, 32'hDEADBEEF, e_err, e_rdata, e_lat, e_pul);
      run_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'h4, 32'hDEADBEEF, 5'd3, 1'b1,
              o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
      n_checks++;
      if (o_err !== e_err || o_pul != 1 || o_addr !== 32'h104 || o_lat != e_lat) begin
         n_fail++;
         $display("FAIL word_store: err=%b pulses=%0d addr=%h lat=%0d, required %b 1 104 %0d", o_err, o_pul, o_addr, o_lat, e_err, e_lat);
      end
      model(1'b0, 2'b10, 1'b0, 32'h100, 32'h4, 32'h0, e_err, e_rdata, e_lat, e_pul);
      run_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h4, 32'h0, 5'd9, 1'b1,
              o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
      n_checks++;
      if (o_rdata !== e_rdata || o_rdata !== 32'hDEADBEEF || o_err !== 2'b00) begin
         n_fail++;
         $display("FAIL word_load: rdata=%h err=%b, required %h 00", o_rdata, o_err, e_rdata);
      end
      n_checks++;
      if (o_lat != 2 || o_pul != 0 || o_rd !== 5'd9) begin
         n_fail++;
         $display("FAIL word_load_timing: lat=%0d pulses=%0d rd=%0d, required 2 0 9", o_lat, o_pul, o_rd);
      end
   endtask

   task automatic test_byte_ext();
      model(1'b1, 2'b00, 1'b0, 32'h200, 32'h3, 32'h80, e_err, e_rdata, e_lat, e_pul);
      run_txn(1'b1, 2'b00, 1'b0, 32'h200, 32'h3, 32'h80, 5'd1, 1'b1,
              o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
      n_checks++;
      if (o_err !== 2'b00 || o_pul != 1 || o_hb !== 2'b00 || o_addr !== 32'h203) begin
         n_fail++;
         $display("FAIL byte_store: err=%b pulses=%0d hb=%b addr=%h, required 00 1 00 203", o_err, o_pul, o_hb, o_addr);
      end
      model(1'b0, 2'b00, 1'b0, 32'h200, 32'h3, 32'h0, e_err, e_rdata, e_lat, e_pul);
      run_txn(1'b0, 2'b00, 1'b0, 32'h200, 32'h3, 32'h0, 5'd2, 1'b1,
              o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
      n_checks++;
      if (o_rdata !== e_rdata || o_rdata !== 32'hFFFFFF80 || o_hb !== 2'b00 || o_ul !== 1'b0) begin
         n_fail++;
         $display("FAIL byte_signed: rdata=%h hb=%b ul=%b, required FFFFFF80 00 0", o_rdata, o_hb, o_ul);
      end
      model(1'b0, 2'b00, 1'b1, 32'h200, 32'h3, 32'h0, e_err, e_rdata, e_lat, e_pul);
      run_txn(1'b0, 2'b00, 1'b1, 32'h200, 32'h3, 32'h0, 5'd4, 1'b1,
              o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
      n_checks++;
      if (o_rdata !== e_rdata || o_rdata !== 32'h00000080 || o_ul !== 1'b1) begin
         n_fail++;
         $display("FAIL byte_unsigned: rdata=%h ul=%b, required 00000080 1", o_rdata, o_ul);
      end
   endtask

   task automatic test_misalign();
      model(1'b0, 2'b01, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, e_err, e_rdata, e_lat, e_pul);
      run_txn(1'b0, 2'b01, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 5'd5, 1'b1,
              o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
      n_checks++;
      if (o_err !== 2'b01 || o_lat != 1 || o_pul != 0 || o_rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL half_misalign: err=%b lat=%0d pulses=%0d rdata=%h, required 01 1 0 0", o_err, o_lat, o_pul, o_rdata);
      end
      model(1'b1, 2'b10, 1'b0, 32'h100, 32'h2, 32'h11223344, e_err, e_rdata, e_lat, e_pul);
      run_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'h2, 32'h11223344, 5'd6, 1'b1,
              o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
      n_checks++;
      if (o_err !== e_err || o_err !== 2'b01 || o_pul != 0) begin
         n_fail++;
         $display("FAIL word_store_misalign: err=%b pulses=%0d, required 01 0", o_err, o_pul);
      end
   endtask

   task automatic test_range_size();
      model(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, e_err, e_rdata, e_lat, e_pul);
      run_txn(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 5'd7, 1'b1,
              o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
      n_checks++;
      if (o_err !== 2'b10 || o_lat != 1 || o_rd !== 5'd7) begin
         n_fail++;
         $display("FAIL range: err=%b lat=%0d rd=%0d, required 10 1 7", o_err, o_lat, o_rd);
      end
      run_txn(1'b0, 2'b11, 1'b0, 32'h400, 32'h1, 32'h0, 5'd8, 1'b1,
              o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
      n_checks++;
      if (o_err !== 2'b11 || o_lat != 1 || o_pul != 0) begin
         n_fail++;
         $display("FAIL illegal_size: err=%b lat=%0d pulses=%0d, required 11 1 0", o_err, o_lat, o_pul);
      end
   endtask

   task automatic test_back_pressure();
      logic [31:0] h_rdata;
      model(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h0, e_err, e_rdata, e_lat, e_pul);
      run_txn(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h0, 5'd17, 1'b0,
              o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
      n_checks++;
      if (o_rdata !== e_rdata || o_err !== e_err || o_rd !== 5'd17) begin
         n_fail++;
         $display("FAIL bp_resp: rdata=%h err=%b rd=%0d, required %h %b 17", o_rdata, o_err, o_rd, e_rdata, e_err);
      end
      h_rdata = o_rdata;
      req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
      req_base_i = 32'h300; req_offset_i = 32'h0; req_wdata_i = 32'h5A; req_rd_i = 5'd18;
      req_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i); #1;
         n_checks++;
         if (resp_valid_o !== 1'b1 || resp_rdata_o !== h_rdata || resp_rd_o !== 5'd17 ||
             resp_err_o !== 2'b00 || req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: valid=%b rdata=%h rd=%0d err=%b ready=%b, required 1 %h 17 00 0",
                     i, resp_valid_o, resp_rdata_o, resp_rd_o, resp_err_o, req_ready_o, h_rdata);
         end
      end
      resp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      resp_ready_i = 1'b0;
      n_checks++;
      if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: ready=%b valid=%b, required 1 0", req_ready_o, resp_valid_o);
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      n_checks++;
      if (req_ready_o !== 1'b0 || ram_we_o !== 1'b1 || ram_addr_o !== 32'h300) begin
         n_fail++;
         $display("FAIL bp_next_accept: ready=%b we=%b addr=%h, required 0 1 300", req_ready_o, ram_we_o, ram_addr_o);
      end
      model(1'b1, 2'b00, 1'b0, 32'h300, 32'h0, 32'h5A, e_err, e_rdata, e_lat, e_pul);
      @(posedge clk_i); #1;
      n_checks++;
      if (resp_valid_o !== 1'b1 || resp_err_o !== 2'b00 || resp_rd_o !== 5'd18 || resp_rdata_o !== 32'd0) begin
         n_fail++;
         $display("FAIL bp_next_resp: valid=%b err=%b rd=%0d rdata=%h, required 1 00 18 0", resp_valid_o, resp_err_o, resp_rd_o, resp_rdata_o);
      end
      resp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      resp_ready_i = 1'b0;
   endtask

   task automatic test_random();
      logic        we, uns;
      logic [1:0]  sz;
      logic [31:0] base, off, wd;
      logic [4:0]  rd;
      for (int i = 0; i < 60; i++) begin
         we   = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1));
         sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         base = 32'($urandom_range(0, 32'h47F));
         off  = 32'($urandom_range(0, 16)) - 32'd8;
         if (sz == 2'b10 && $urandom_range(0, 3) != 0) off = off & 32'hFFFF_FFFC;
         wd   = $urandom;
         rd   = 5'($urandom);
         model(we, sz, uns, base & 32'hFFFF_FFFC, off, wd, e_err, e_rdata, e_lat, e_pul);
         run_txn(we, sz, uns, base & 32'hFFFF_FFFC, off, wd, rd, 1'b1,
                 o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
         n_checks++;
         if (o_err !== e_err || o_rdata !== e_rdata || o_rd !== rd || o_lat != e_lat || o_pul != e_pul) begin
            n_fail++;
            $display("FAIL rand[%0d]: err=%b rdata=%h rd=%0d lat=%0d pulses=%0d, required %b %h %0d %0d %0d",
                     i, o_err, o_rdata, o_rd, o_lat, o_pul, e_err, e_rdata, rd, e_lat, e_pul);
         end
      end
   endtask

   task automatic test_reset_mid();
      req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
      req_base_i = 32'h104; req_offset_i = 32'h0; req_wdata_i = 32'h12345678; req_rd_i = 5'd21;
      req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      n_checks++;
      if (ram_we_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_access: we=%b required 1", ram_we_o);
      end
      rst_i = 1'b1;
      #1;
      n_checks++;
      if (ram_we_o !== 1'b0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || ram_hb_o !== 2'b10 ||
          ram_addr_o !== 32'd0 || ram_wdata_o !== 32'd0 || resp_rd_o !== 5'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: we=%b valid=%b ready=%b hb=%b addr=%h wdata=%h rd=%0d, required 0 0 0 10 0 0 0",
                  ram_we_o, resp_valid_o, req_ready_o, ram_hb_o, ram_addr_o, ram_wdata_o, resp_rd_o);
      end
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
      n_checks++;
      if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_release: ready=%b valid=%b, required 1 0", req_ready_o, resp_valid_o);
      end
      model(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h0, e_err, e_rdata, e_lat, e_pul);
      run_txn(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h0, 5'd22, 1'b1,
              o_rdata, o_err, o_rd, o_lat, o_pul, o_hb, o_addr, o_ul);
      n_checks++;
      if (o_rdata !== e_rdata || o_err !== 2'b00) begin
         n_fail++;
         $display("FAIL rstmid_no_write: rdata=%h err=%b, required %h 00", o_rdata, o_err, e_rdata);
      end
   endtask

   initial begin
      req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
      req_base_i = '0; req_offset_i = '0; req_wdata_i = '0; req_rd_i = '0;
      resp_ready_i = 1'b0;
      test_reset();
      test_word_store_load();
      test_byte_ext();
      test_misalign();
      test_range_size();
      test_back_pressure();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the execute stage and the data `ram`. It accepts one memory request at a time over a valid/ready handshake and computes the effective address. It checks alignment and range, then drives the RAM port (address, write data, write enable, size, unsigned flag) for exactly one cycle. It returns a registered response with load data or an error code to the writeback stage.

## Interface
Parameters:
- `MEM_BASE`, default 32'h0000_0000: byte base address of the RAM window.
- `MEM_SIZE`, default 1024: RAM window size in bytes; power of two, a multiple of 4.

Ports:
- `clk_i`  in  1  system clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  LSU can accept a request.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned_i`  in  1  zero-extend the load result.
- `req_base_i`  in  32  base register value.
- `req_offset_i`  in  32  sign-extended immediate.
- `req_wdata_i`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_rd_i`  in  5  destination register tag.
- `ram_addr_o`  out  32  byte address to RAM.
- `ram_wdata_o`  out  32  store data to RAM, unshifted.
- `ram_we_o`  out  1  RAM write enable.
- `ram_hb_o`  out  2  RAM size code (same encoding as `req_size_i`); never 11.
- `ram_uload_o`  out  1  RAM unsigned-load select.
- `ram_rdata_i`  in  32  RAM combinational read data, already extended.
- `resp_valid_o`  out  1  response present.
- `resp_ready_i`  in  1  writeback accepts the response.
- `resp_rdata_o`  out  32  load result; 0 for stores and errors.
- `resp_rd_o`  out  5  echoed `req_rd_i`.
- `resp_err_o`  out  2  00 = ok, 01 = misaligned, 10 = out of range, 11 = illegal size.

## Operation
- FSM states are IDLE, ACCESS and RESP. Reset enters IDLE.
- **IDLE:**
  - `req_ready_o`=1 (forced 0 while `rst_i`=1).
  - On `req_valid_i`&&`req_ready_o`: latch the request fields and the effective address `ea = req_base_i + req_offset_i` (32-bit, modulo 2^32).
  - Classify the request in this priority order:
    - size 11 → err 11;
    - half with `ea[0]`≠0, or word with `ea[1:0]`≠0 → err 01;
    - `ea` outside [MEM_BASE, MEM_BASE+MEM_SIZE) → err 10.
  - Error → RESP without a RAM access. Otherwise → ACCESS.
- **ACCESS:**
  - Drive `ram_addr_o`=`ea`, `ram_hb_o`=latched size, `ram_uload_o`=latched unsigned, `ram_wdata_o`=latched wdata, `ram_we_o`=latched we.
  - Load: register `ram_rdata_i` into `resp_rdata_o` at the end of the cycle. Store: `resp_rdata_o`=0.
  - Always → RESP.
- **RESP:**
  - `resp_valid_o`=1; `resp_rdata_o`, `resp_rd_o` and `resp_err_o` are held stable.
  - `req_ready_o`=0.
  - On `resp_ready_i` → IDLE.
- Outside ACCESS: `ram_we_o`=0, `ram_hb_o`=10, `ram_uload_o`=0. `ram_addr_o` and `ram_wdata_o` hold their last latched values.
- **Reset:**
  - All registered outputs are 0 and the state is IDLE.
  - `ram_hb_o`=10; `req_ready_o`=1 once `rst_i` deasserts.
  - A reset in ACCESS or RESP aborts the transaction: no response is issued, and `ram_we_o` drops immediately.

## Timing
- Request accepted at edge T.
- Good access: ACCESS in cycle T..T+1; RAM write commits at edge T+1; `resp_valid_o` asserts after edge T+1.
- Error: `resp_valid_o` asserts after edge T; RAM is untouched.
- Back-pressure: the response is held indefinitely while `resp_ready_i`=0.
- Peak throughput is one request per 3 cycles, or per 2 cycles for errors. The next accept happens the cycle after the response handshake.
- `ram_we_o` is high for exactly one cycle per store, never for a load or an errored request.

## Structure
- Shared package `mem_pkg` holds:
  - size codes `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`/`SZ_ILL`;
  - error codes `ERR_OK`/`ERR_MISALIGN`/`ERR_RANGE`/`ERR_SIZE`;
  - the FSM state encoding.
- The same package is reused by `ram` and by the bus decoder.
- Sub-module `lsu_addr_check` (combinational) computes `ea` and the error classification from base, offset and size, with `MEM_BASE`/`MEM_SIZE` passed as parameters.

## Test plan
- **Aligned word store then load:**
  - Store base=0x100, off=0x4, wdata=0xDEADBEEF, size 10.
  - `ram_we_o` is a single pulse at addr 0x104.
  - The load from the same address returns `resp_rdata_o`=0xDEADBEEF with err 00, two cycles after accept.
- **Byte sign/zero extension:**
  - Store byte 0x80 to 0x203.
  - A signed byte load returns 0xFFFFFF80; an unsigned byte load returns 0x00000080.
  - `ram_hb_o`=00 during ACCESS.
- **Misalignment and negative offset:**
  - Half load at base=0x10, off=-1 (ea=0xF) → err 01 after 1 cycle; `ram_we_o` never asserts.
  - Word store at 0x102 → err 01.
- **Range and illegal size:**
  - Word load at 0x400 with MEM_SIZE=1024 → err 10.
  - Size 11 at 0x401 → err 11, since illegal size takes priority.
- **Back-pressure:**
  - Hold `resp_ready_i`=0 for 5 cycles.
  - The response stays stable, `req_ready_o`=0 throughout, and a pending `req_valid_i` is accepted the cycle after the handshake.
- **Reset mid-transaction:**
  - Assert `rst_i` during ACCESS of a store.
  - `ram_we_o` drops immediately, no response is issued, and all outputs return to their reset values.
